pattern_eval_scheduler: RTL and testbench
=========================================

// Module: pattern_eval_scheduler
// PURPOSE
//  Sequences the Hungarian-matching evaluator that compares the modelled juggling pattern with tracked balls.
//  - Snapshots one frame of model/real positions; holds them stable for the whole evaluator run.
//  - Resets the evaluator between runs, pulses its start, waits for completion with a timeout.
//  - Buffers one pending frame. Publishes per-frame results plus a correct-frame streak.
// PARAMETERS
//  TIMEOUT_CYCLES  4096  max WAIT cycles before the run is abandoned (worst-case 7-ball run is ~1.5k cycles)
//  CLEAR_CYCLES    2     cycles eval_rst_out is held high before each start (minimum 2)
// PORTS
//  clk_in               in   1        single clock
//  rst_in               in   1        asynchronous, active-high reset
//  frame_valid_in       in   1        1-cycle strobe: frame inputs below are valid
//  num_balls_in         in   3        balls in frame, 1..7
//  model_x_in[6:0]      in   11 each  model ball x
//  model_y_in[6:0]      in   10 each  model ball y
//  real_x_in[6:0]       in   11 each  tracked ball x
//  real_y_in[6:0]       in   10 each  tracked ball y
//  eval_rst_out         out  1        evaluator reset
//  eval_valid_out       out  1        evaluator start strobe
//  eval_num_balls_out   out  3        snapshot ball count, to evaluator
//  eval_model_x_out[6:0], eval_model_y_out[6:0], eval_real_x_out[6:0], eval_real_y_out[6:0]
//                       out  11/10    snapshot positions, to evaluator
//  eval_valid_in        in   1        evaluator done (level, stays high in its ANS state)
//  eval_error_in        in   15 s     evaluator total squared error
//  eval_correct_in      in   1        evaluator verdict
//  result_valid_out     out  1        1-cycle pulse: result outputs updated
//  pattern_error_out    out  15 s     last error; holds until next result
//  pattern_correct_out  out  1        last verdict; holds until next result
//  streak_out           out  8        consecutive correct frames, saturates at 255
//  frames_dropped_out   out  8        overwritten pending frames, saturates at 255
//  timeout_out          out  1        1-cycle pulse on timeout
//  busy_out             out  1        high in every state except IDLE
// BEHAVIOUR
//  Reset values
//  - All outputs 0, except eval_rst_out=1. Snapshot and pending registers cleared; pending flag 0.
//  FSM states: IDLE, CLEAR, START, WAIT, DONE.
//  - IDLE: if pending or frame_valid_in, load snapshot (pending takes priority; the new frame then becomes pending) -> CLEAR.
//  - CLEAR: eval_rst_out=1 for CLEAR_CYCLES; eval_rst_out=1 in IDLE too. -> START.
//  - START: eval_rst_out=0, eval_valid_out=1 for exactly one cycle -> WAIT.
//  - WAIT: eval_valid_in=1 -> DONE, capturing eval_error_in and eval_correct_in.
//  - WAIT: cycle counter reaching TIMEOUT_CYCLES -> timeout_out pulse, streak cleared, no result_valid_out -> IDLE.
//  - DONE: result_valid_out=1 for one cycle; update streak (+1 saturating if correct, else 0) -> IDLE.
//  Latency
//  - frame_valid_in in IDLE at cycle N: eval_valid_out at cycle N+1+CLEAR_CYCLES.
//  - result_valid_out: one cycle after eval_valid_in is first seen in WAIT.
//  Stale-done guard
//  - eval_valid_in is ignored in all states except WAIT. The CLEAR window guarantees the evaluator has zeroed its done flag.
//  Snapshot stability
//  - eval_* outputs change only on the IDLE->CLEAR transition.
//  Input validation
//  - num_balls_in==0: frame discarded; not counted, no result.
//  Busy handling
//  - frame_valid_in while busy_out: stored in the pending slot.
//  - If the slot is already full it is overwritten and frames_dropped_out increments.
//  - frame_valid_in on the same cycle the pending slot is consumed: the new frame lands in the slot and no drop is counted.
//  Reset mid-run
//  - Async reset returns to IDLE immediately. Pending frame and counters are lost.
// STRUCTURE
//  - Package pattern_pkg: MAX_BALLS=7, X_W=11, Y_W=10, ERR_W=15, frame_t struct {num_balls, mx[7], my[7], rx[7], ry[7]}, sched_state_t enum.
//  - Sub-module pattern_frame_slot: one frame_t register with load/valid/overwrite-flag. Instantiated twice (snapshot, pending).
// TESTING
//  1. 3-ball frame, evaluator model returns valid after 200 cycles with err=100, correct=1
//     -> eval_rst_out high 2 cycles, eval_valid_out at N+3, result pulse, error 100, streak 1.
//  2. Evaluator held done=1 from the previous run when the new frame arrives -> no result before the new START; exactly one result per frame.
//  3. Evaluator never responds -> timeout_out at WAIT cycle 4096, streak cleared, returns to IDLE, next frame runs normally.
//  4. Three frames spaced 10 cycles apart during a run -> frames_dropped_out=1; second run uses the third frame.
//  5. 300 consecutive correct frames -> streak_out saturates at 255; one incorrect frame -> 0.
//  6. rst_in asserted in WAIT -> outputs return to reset values in the same cycle; num_balls_in=0 frame produces no activity.

Source files
------------

// File: rtl/pattern_eval_scheduler_pkg.sv
// Shared types and widths for the pattern evaluator scheduler.
//   MAX_BALLS / X_W / Y_W / ERR_W / NB_W : frame geometry and result widths
//   frame_t       : one frame of model and tracked ball positions
//   sched_state_t : scheduler FSM states
package pattern_pkg;

  localparam int MAX_BALLS = 7;
  localparam int X_W       = 11;
  localparam int Y_W       = 10;
  localparam int ERR_W     = 15;
  localparam int NB_W      = 3;

  typedef struct packed {
    logic [NB_W-1:0]                num_balls;
    logic [MAX_BALLS-1:0][X_W-1:0]  mx;
    logic [MAX_BALLS-1:0][Y_W-1:0]  my;
    logic [MAX_BALLS-1:0][X_W-1:0]  rx;
    logic [MAX_BALLS-1:0][Y_W-1:0]  ry;
  } frame_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } sched_state_t;

endpackage

// File: rtl/pattern_eval_scheduler_if.sv
// Scheduler <-> Hungarian evaluator link.
//   master : scheduler side (drives reset, start strobe and frame snapshot;
//            receives done level, total squared error and verdict)
//   slave  : evaluator side
interface pattern_eval_scheduler_if;
  import pattern_pkg::*;

  logic                    eval_rst_out;
  logic                    eval_valid_out;
  logic [NB_W-1:0]         eval_num_balls_out;
  logic [X_W-1:0]          eval_model_x_out [MAX_BALLS-1:0];
  logic [Y_W-1:0]          eval_model_y_out [MAX_BALLS-1:0];
  logic [X_W-1:0]          eval_real_x_out  [MAX_BALLS-1:0];
  logic [Y_W-1:0]          eval_real_y_out  [MAX_BALLS-1:0];
  logic                    eval_valid_in;
  logic signed [ERR_W-1:0] eval_error_in;
  logic                    eval_correct_in;

  modport master (
    output eval_rst_out, eval_valid_out, eval_num_balls_out,
           eval_model_x_out, eval_model_y_out, eval_real_x_out, eval_real_y_out,
    input  eval_valid_in, eval_error_in, eval_correct_in
  );

  modport slave (
    input  eval_rst_out, eval_valid_out, eval_num_balls_out,
           eval_model_x_out, eval_model_y_out, eval_real_x_out, eval_real_y_out,
    output eval_valid_in, eval_error_in, eval_correct_in
  );

endinterface

// File: rtl/pattern_eval_scheduler_frame_slot.sv
// One-frame holding register.
//   clk_in, rst_in : clock, async active-high reset
//   load           : capture frame_d (wins over clear)
//   clear          : drop the valid flag (frame was consumed)
//   frame_d        : frame to capture
//   frame_q, valid : held frame and its valid flag
//   overwrite      : a valid, unconsumed frame is being replaced this cycle
module pattern_frame_slot
  import pattern_pkg::*;
(
  input  logic   clk_in,
  input  logic   rst_in,
  input  logic   load,
  input  logic   clear,
  input  frame_t frame_d,
  output frame_t frame_q,
  output logic   valid,
  output logic   overwrite
);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      frame_q <= '0;
      valid   <= 1'b0;
    end else if (load) begin
      frame_q <= frame_d;
      valid   <= 1'b1;
    end else if (clear) begin
      valid   <= 1'b0;
    end
  end

  assign overwrite = load & valid & ~clear;

endmodule

// File: rtl/pattern_eval_scheduler.sv
// Sequences one Hungarian-matching evaluator run per frame.
//   clk_in, rst_in          : clock, async active-high reset
//   frame_valid_in + frame  : 1-cycle frame strobe with ball count and positions
//   bus (master)            : evaluator reset/start/snapshot out, done/error/verdict in
//   result_valid_out        : 1-cycle pulse, result outputs updated
//   pattern_error_out/_correct_out : last evaluator result, held
//   streak_out              : consecutive correct frames (saturating)
//   frames_dropped_out      : overwritten pending frames (saturating)
//   timeout_out             : 1-cycle pulse when a run is abandoned
//   busy_out                : scheduler not idle
module pattern_eval_scheduler
  import pattern_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CLEAR_CYCLES   = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    frame_valid_in,
  input  logic [NB_W-1:0]         num_balls_in,
  input  logic [X_W-1:0]          model_x_in [MAX_BALLS-1:0],
  input  logic [Y_W-1:0]          model_y_in [MAX_BALLS-1:0],
  input  logic [X_W-1:0]          real_x_in  [MAX_BALLS-1:0],
  input  logic [Y_W-1:0]          real_y_in  [MAX_BALLS-1:0],
  pattern_eval_scheduler_if.master bus,
  output logic                    result_valid_out,
  output logic signed [ERR_W-1:0] pattern_error_out,
  output logic                    pattern_correct_out,
  output logic [7:0]              streak_out,
  output logic [7:0]              frames_dropped_out,
  output logic                    timeout_out,
  output logic                    busy_out
);

  // The evaluator needs at least two reset cycles to clear its done flag.
  localparam int unsigned CLR_N = (CLEAR_CYCLES < 2) ? 2 : CLEAR_CYCLES;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_t state;
  logic [CNT_W-1:0] cnt;

  frame_t in_frame, snap_d, snap_q, pend_q;
  logic   pend_valid, pend_ovr;
  logic   snap_valid_unused, snap_ovr_unused;
  logic   frame_ok, take, consume, pend_load;

  always_comb begin
    in_frame           = '0;
    in_frame.num_balls = num_balls_in;
    for (int unsigned i = 0; i < MAX_BALLS; i++) begin
      in_frame.mx[i] = model_x_in[i];
      in_frame.my[i] = model_y_in[i];
      in_frame.rx[i] = real_x_in[i];
      in_frame.ry[i] = real_y_in[i];
    end
  end

  // Empty frames are discarded before they reach either slot.
  assign frame_ok = frame_valid_in && (num_balls_in != '0);
  // A queued frame is always launched ahead of one arriving this cycle;
  // the arriving frame then replaces it in the pending slot, which is
  // not an overwrite because the old contents were consumed.
  assign consume   = (state == S_IDLE) && pend_valid;
  assign take      = (state == S_IDLE) && (pend_valid || frame_ok);
  assign pend_load = frame_ok && ((state != S_IDLE) || pend_valid);
  assign snap_d    = pend_valid ? pend_q : in_frame;

  pattern_frame_slot u_snap (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .load      (take),
    .clear     (1'b0),
    .frame_d   (snap_d),
    .frame_q   (snap_q),
    .valid     (snap_valid_unused),
    .overwrite (snap_ovr_unused)
  );

  pattern_frame_slot u_pend (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .load      (pend_load),
    .clear     (consume),
    .frame_d   (in_frame),
    .frame_q   (pend_q),
    .valid     (pend_valid),
    .overwrite (pend_ovr)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state               <= S_IDLE;
      cnt                 <= '0;
      pattern_error_out   <= '0;
      pattern_correct_out <= 1'b0;
      streak_out          <= '0;
      frames_dropped_out  <= '0;
      timeout_out         <= 1'b0;
    end else begin
      timeout_out <= 1'b0;
      if (pend_ovr && (frames_dropped_out != 8'hFF))
        frames_dropped_out <= frames_dropped_out + 8'd1;

      case (state)
        S_IDLE: begin
          if (take) begin
            state <= S_CLEAR;
            cnt   <= '0;
          end
        end
        S_CLEAR: begin
          if (cnt == CNT_W'(CLR_N - 1)) state <= S_START;
          else                           cnt   <= cnt + 1'b1;
        end
        S_START: begin
          state <= S_WAIT;
          cnt   <= '0;
        end
        S_WAIT: begin
          // Result and streak are registered together so they are all
          // valid during the DONE pulse.
          if (bus.eval_valid_in) begin
            pattern_error_out   <= bus.eval_error_in;
            pattern_correct_out <= bus.eval_correct_in;
            if (!bus.eval_correct_in)       streak_out <= '0;
            else if (streak_out != 8'hFF)   streak_out <= streak_out + 8'd1;
            state <= S_DONE;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_out <= 1'b1;
            streak_out  <= '0;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.eval_rst_out   = (state == S_IDLE) || (state == S_CLEAR);
  assign bus.eval_valid_out = (state == S_START);
  assign result_valid_out   = (state == S_DONE);
  assign busy_out           = (state != S_IDLE);

  always_comb begin
    bus.eval_num_balls_out = snap_q.num_balls;
    for (int unsigned i = 0; i < MAX_BALLS; i++) begin
      bus.eval_model_x_out[i] = snap_q.mx[i];
      bus.eval_model_y_out[i] = snap_q.my[i];
      bus.eval_real_x_out[i]  = snap_q.rx[i];
      bus.eval_real_y_out[i]  = snap_q.ry[i];
    end
  end

endmodule

// File: tb/tb_pattern_eval_scheduler.sv
module tb_pattern_eval_scheduler;
  import pattern_pkg::*;

  typedef struct {
    int nb;
    int mx[MAX_BALLS];
    int my[MAX_BALLS];
    int rx[MAX_BALLS];
    int ry[MAX_BALLS];
  } tb_frame_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic                    frame_valid_in;
  logic [NB_W-1:0]         num_balls_in;
  logic [X_W-1:0]          model_x_in [MAX_BALLS-1:0];
  logic [Y_W-1:0]          model_y_in [MAX_BALLS-1:0];
  logic [X_W-1:0]          real_x_in  [MAX_BALLS-1:0];
  logic [Y_W-1:0]          real_y_in  [MAX_BALLS-1:0];
  logic                    result_valid_out;
  logic signed [ERR_W-1:0] pattern_error_out;
  logic                    pattern_correct_out;
  logic [7:0]              streak_out;
  logic [7:0]              frames_dropped_out;
  logic                    timeout_out;
  logic                    busy_out;

  pattern_eval_scheduler_if eif();

  pattern_eval_scheduler #(.TIMEOUT_CYCLES(4096), .CLEAR_CYCLES(2)) dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .frame_valid_in      (frame_valid_in),
    .num_balls_in        (num_balls_in),
    .model_x_in          (model_x_in),
    .model_y_in          (model_y_in),
    .real_x_in           (real_x_in),
    .real_y_in           (real_y_in),
    .bus                 (eif),
    .result_valid_out    (result_valid_out),
    .pattern_error_out   (pattern_error_out),
    .pattern_correct_out (pattern_correct_out),
    .streak_out          (streak_out),
    .frames_dropped_out  (frames_dropped_out),
    .timeout_out         (timeout_out),
    .busy_out            (busy_out)
  );

  int n_cmp = 0;
  int n_err = 0;
  int exp_streak  = 0;   // consecutive correct verdicts, capped at 255
  int exp_dropped = 0;   // pending frames overwritten before use
  tb_frame_t cur;        // frame the evaluator should currently be seeing

  task automatic rand_frame(input int nb, output tb_frame_t f);
    f.nb = nb;
    for (int i = 0; i < MAX_BALLS; i++) begin
      f.mx[i] = int'($urandom_range(0, 2047));
      f.my[i] = int'($urandom_range(0, 1023));
      f.rx[i] = int'($urandom_range(0, 2047));
      f.ry[i] = int'($urandom_range(0, 1023));
    end
  endtask

  task automatic apply_frame(input tb_frame_t f);
    frame_valid_in = 1'b1;
    num_balls_in   = 3'(f.nb);
    for (int i = 0; i < MAX_BALLS; i++) begin
      model_x_in[i] = 11'(f.mx[i]);
      model_y_in[i] = 10'(f.my[i]);
      real_x_in[i]  = 11'(f.rx[i]);
      real_y_in[i]  = 10'(f.ry[i]);
    end
  endtask

  function automatic bit snap_ok(input tb_frame_t f);
    bit ok;
    ok = (int'(eif.eval_num_balls_out) == f.nb);
    for (int i = 0; i < MAX_BALLS; i++) begin
      ok &= (int'(eif.eval_model_x_out[i]) == f.mx[i]) && (int'(eif.eval_model_y_out[i]) == f.my[i]);
      ok &= (int'(eif.eval_real_x_out[i])  == f.rx[i]) && (int'(eif.eval_real_y_out[i])  == f.ry[i]);
    end
    return ok;
  endfunction

  // Called at an IDLE negedge; ends at the START negedge.
  task automatic launch(input tb_frame_t f, input bit drive);
    if (drive) apply_frame(f);
    cur = f;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk_in);
      frame_valid_in = 1'b0;
      if (c == 2) eif.eval_valid_in = 1'b0;  // evaluator has zeroed its done flag under reset
      n_cmp++;
      if (c < 3) begin
        if (eif.eval_rst_out !== 1'b1 || eif.eval_valid_out !== 1'b0 || result_valid_out !== 1'b0 || busy_out !== 1'b1) begin
          n_err++;
          $display("FAIL clear_phase c=%0d: rst=%b start=%b result=%b busy=%b, required rst=1 start=0 result=0 busy=1",
                   c, eif.eval_rst_out, eif.eval_valid_out, result_valid_out, busy_out);
        end
      end else begin
        if (eif.eval_rst_out !== 1'b0 || eif.eval_valid_out !== 1'b1 || result_valid_out !== 1'b0) begin
          n_err++;
          $display("FAIL start_latency: rst=%b start=%b result=%b, required rst=0 start=1 result=0",
                   eif.eval_rst_out, eif.eval_valid_out, result_valid_out);
        end
      end
    end
    n_cmp++;
    if (!snap_ok(f)) begin
      n_err++;
      $display("FAIL snapshot: num_balls=%0d mx0=%0d ry6=%0d, required num_balls=%0d mx0=%0d ry6=%0d",
               eif.eval_num_balls_out, eif.eval_model_x_out[0], eif.eval_real_y_out[6], f.nb, f.mx[0], f.ry[6]);
    end
  endtask

  // Called at the START negedge (or later in WAIT); ends at the following IDLE negedge.
  task automatic finish_run(input int lat, input int err, input bit corr, input bit hold);
    bit quiet = 1'b1;
    bit stable = 1'b1;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk_in);
      if (result_valid_out !== 1'b0 || busy_out !== 1'b1 || eif.eval_valid_out !== 1'b0) quiet = 1'b0;
      if (!snap_ok(cur)) stable = 1'b0;
      if (c == lat) begin
        eif.eval_valid_in   = 1'b1;
        eif.eval_error_in   = 15'(err);
        eif.eval_correct_in = corr;
      end
    end
    @(negedge clk_in);
    exp_streak = corr ? ((exp_streak >= 255) ? 255 : exp_streak + 1) : 0;
    n_cmp++;
    if (!quiet) begin n_err++; $display("FAIL wait_quiet: activity seen while waiting, required none"); end
    n_cmp++;
    if (!stable) begin n_err++; $display("FAIL snapshot_stable: evaluator inputs changed during run, required held"); end
    n_cmp++;
    if (result_valid_out !== 1'b1) begin n_err++; $display("FAIL result_pulse: got %b required 1", result_valid_out); end
    n_cmp++;
    if (int'(pattern_error_out) != err) begin n_err++; $display("FAIL result_error: got %0d required %0d", pattern_error_out, err); end
    n_cmp++;
    if (pattern_correct_out !== corr) begin n_err++; $display("FAIL result_correct: got %b required %b", pattern_correct_out, corr); end
    n_cmp++;
    if (int'(streak_out) != exp_streak) begin n_err++; $display("FAIL streak: got %0d required %0d", streak_out, exp_streak); end
    if (!hold) eif.eval_valid_in = 1'b0;
    @(negedge clk_in);
    n_cmp++;
    if (result_valid_out !== 1'b0 || busy_out !== 1'b0) begin
      n_err++;
      $display("FAIL result_once: result=%b busy=%b, required result=0 busy=0", result_valid_out, busy_out);
    end
  endtask

  task automatic test_reset;
    rst_in = 1'b0;
    #2 rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    n_cmp++;
    if (eif.eval_rst_out !== 1'b1 || eif.eval_valid_out !== 1'b0 || busy_out !== 1'b0 || result_valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: rst=%b start=%b busy=%b result=%b, required 1 0 0 0",
               eif.eval_rst_out, eif.eval_valid_out, busy_out, result_valid_out);
    end
    n_cmp++;
    if (streak_out !== 8'd0 || frames_dropped_out !== 8'd0 || timeout_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset_counters: streak=%0d dropped=%0d timeout=%b, required 0 0 0", streak_out, frames_dropped_out, timeout_out);
    end
    n_cmp++;
    if (pattern_error_out !== '0 || pattern_correct_out !== 1'b0 || eif.eval_num_balls_out !== '0) begin
      n_err++;
      $display("FAIL reset_results: err=%0d correct=%b nb=%0d, required 0 0 0", pattern_error_out, pattern_correct_out, eif.eval_num_balls_out);
    end
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_basic;
    tb_frame_t f;
    rand_frame(3, f);
    launch(f, 1'b1);
    finish_run(200, 100, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      rand_frame(int'($urandom_range(1, 7)), f);
      launch(f, 1'b1);
      finish_run(int'($urandom_range(1, 40)), int'($urandom_range(0, 32767)) - 16384, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic test_stale_done;
    tb_frame_t f;
    rand_frame(int'($urandom_range(1, 7)), f);
    launch(f, 1'b1);
    finish_run(20, -500, 1'b1, 1'b1);   // evaluator keeps done high afterwards
    rand_frame(int'($urandom_range(1, 7)), f);
    launch(f, 1'b1);
    finish_run(30, 77, 1'b1, 1'b0);
  endtask

  task automatic test_timeout;
    tb_frame_t f;
    int k = 0;
    bit seen = 1'b0;
    bit spurious = 1'b0;
    rand_frame(int'($urandom_range(1, 7)), f);
    launch(f, 1'b1);
    while (!seen && k < 4200) begin
      @(negedge clk_in);
      k++;
      if (result_valid_out === 1'b1) spurious = 1'b1;
      if (timeout_out === 1'b1) seen = 1'b1;
    end
    exp_streak = 0;
    n_cmp++;
    if (!seen || k != 4097) begin n_err++; $display("FAIL timeout_cycle: seen=%b after %0d cycles, required 4097", seen, k); end
    n_cmp++;
    if (spurious) begin n_err++; $display("FAIL timeout_no_result: result pulse seen, required none"); end
    n_cmp++;
    if (int'(streak_out) != exp_streak || busy_out !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_state: streak=%0d busy=%b, required streak=0 busy=0", streak_out, busy_out);
    end
    @(negedge clk_in);
    n_cmp++;
    if (timeout_out !== 1'b0) begin n_err++; $display("FAIL timeout_pulse: got %b required 0", timeout_out); end
    rand_frame(int'($urandom_range(1, 7)), f);
    launch(f, 1'b1);
    finish_run(15, 321, 1'b1, 1'b0);
  endtask

  task automatic test_pending;
    tb_frame_t a, b, c, e;
    rand_frame(int'($urandom_range(1, 7)), a);
    rand_frame(int'($urandom_range(1, 7)), b);
    rand_frame(int'($urandom_range(1, 7)), c);
    rand_frame(int'($urandom_range(1, 7)), e);
    launch(a, 1'b1);                          // a at cycle 0, start at 3
    repeat (7) @(negedge clk_in);
    apply_frame(b);                           // cycle 10
    @(negedge clk_in);
    frame_valid_in = 1'b0;
    repeat (9) @(negedge clk_in);
    apply_frame(c);                           // cycle 20, replaces b
    @(negedge clk_in);
    frame_valid_in = 1'b0;
    exp_dropped++;
    n_cmp++;
    if (int'(frames_dropped_out) != exp_dropped) begin
      n_err++;
      $display("FAIL dropped_overwrite: got %0d required %0d", frames_dropped_out, exp_dropped);
    end
    finish_run(5, 42, 1'b1, 1'b0);
    apply_frame(e);                           // arrives as c is consumed
    launch(c, 1'b0);
    finish_run(8, 43, 1'b0, 1'b0);
    launch(e, 1'b0);
    finish_run(3, -44, 1'b1, 1'b0);
    n_cmp++;
    if (int'(frames_dropped_out) != exp_dropped) begin
      n_err++;
      $display("FAIL dropped_consume_same_cycle: got %0d required %0d", frames_dropped_out, exp_dropped);
    end
  endtask

  task automatic test_streak_saturation;
    tb_frame_t f;
    for (int k = 0; k < 300; k++) begin
      rand_frame(int'($urandom_range(1, 7)), f);
      launch(f, 1'b1);
      finish_run(int'($urandom_range(1, 4)), int'($urandom_range(0, 2000)), 1'b1, 1'b0);
    end
    rand_frame(int'($urandom_range(1, 7)), f);
    launch(f, 1'b1);
    finish_run(2, 9999, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_run;
    tb_frame_t f, g;
    bit idle_ok = 1'b1;
    rand_frame(int'($urandom_range(1, 7)), f);
    launch(f, 1'b1);
    finish_run(4, 1234, 1'b1, 1'b0);
    rand_frame(int'($urandom_range(1, 7)), f);
    rand_frame(int'($urandom_range(1, 7)), g);
    launch(f, 1'b1);
    repeat (5) @(negedge clk_in);
    apply_frame(g);
    @(negedge clk_in);
    frame_valid_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    exp_streak = 0;
    exp_dropped = 0;
    n_cmp++;
    if (busy_out !== 1'b0 || eif.eval_rst_out !== 1'b1 || eif.eval_valid_out !== 1'b0 || eif.eval_num_balls_out !== '0) begin
      n_err++;
      $display("FAIL reset_mid_ctrl: busy=%b rst=%b start=%b nb=%0d, required 0 1 0 0",
               busy_out, eif.eval_rst_out, eif.eval_valid_out, eif.eval_num_balls_out);
    end
    n_cmp++;
    if (int'(streak_out) != exp_streak || pattern_error_out !== '0 || pattern_correct_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_results: streak=%0d err=%0d correct=%b, required 0 0 0", streak_out, pattern_error_out, pattern_correct_out);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (6) begin
      @(negedge clk_in);
      if (busy_out !== 1'b0) idle_ok = 1'b0;
    end
    n_cmp++;
    if (!idle_ok) begin n_err++; $display("FAIL reset_mid_pending_lost: busy seen after reset, required idle"); end
    rand_frame(0, f);
    apply_frame(f);
    idle_ok = 1'b1;
    repeat (6) begin
      @(negedge clk_in);
      frame_valid_in = 1'b0;
      if (busy_out !== 1'b0 || eif.eval_valid_out !== 1'b0 || result_valid_out !== 1'b0) idle_ok = 1'b0;
    end
    n_cmp++;
    if (!idle_ok || int'(frames_dropped_out) != exp_dropped) begin
      n_err++;
      $display("FAIL zero_ball_frame: activity=%b dropped=%0d, required no activity dropped=%0d", !idle_ok, frames_dropped_out, exp_dropped);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_valid_in      = 1'b0;
    num_balls_in        = '0;
    for (int i = 0; i < MAX_BALLS; i++) begin
      model_x_in[i] = '0;
      model_y_in[i] = '0;
      real_x_in[i]  = '0;
      real_y_in[i]  = '0;
    end
    eif.eval_valid_in   = 1'b0;
    eif.eval_error_in   = '0;
    eif.eval_correct_in = 1'b0;

    test_reset();
    test_basic();
    test_stale_done();
    test_timeout();
    test_pending();
    test_streak_saturation();
    test_reset_mid_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
